// File: rtl/game_sprite_motion_sequencer.sv
// Launch/bounce/relaunch sequencer for one sprite control block.
// Reflects speed at screen edges; bottom exit optionally means "ball lost".
//
// state      | meaning
// IDLE       | parked, waiting for start
// LOAD_XY    | one-cycle load of launch position
// LOAD_DXY   | one-cycle load of launch speed
// RUN        | motion enabled, watching edges
// REFLECT    | motion paused, one-cycle load of reflected speed
// LOST       | bottom exit seen, lost pulse, relaunch timer loaded
// WAIT       | relaunch timer counting down to zero
module game_sprite_motion_sequencer #(
  parameter int X_WIDTH         = 10,
  parameter int Y_WIDTH         = 10,
  parameter int DX_WIDTH        = 2,
  parameter int DY_WIDTH        = 2,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SPRITE_W        = 8,
  parameter int SPRITE_H        = 8,
  parameter int START_X         = 320,
  parameter int START_Y         = 240,
  parameter int START_DX        = 1,
  parameter int START_DY        = 1,
  parameter int EXIT_BOTTOM     = 1,
  parameter int RELAUNCH_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [X_WIDTH-1:0]  sprite_x,
  input  logic [Y_WIDTH-1:0]  sprite_y,
  output logic                sprite_write_xy,
  output logic                sprite_write_dxy,
  output logic [X_WIDTH-1:0]  sprite_write_x,
  output logic [Y_WIDTH-1:0]  sprite_write_y,
  output logic [DX_WIDTH-1:0] sprite_write_dx,
  output logic [DY_WIDTH-1:0] sprite_write_dy,
  output logic                sprite_enable_update,
  output logic                busy,
  output logic                lost,
  output logic [7:0]          bounce_count
);

  localparam int CNT_W = (RELAUNCH_CYCLES > 1) ? $clog2(RELAUNCH_CYCLES) : 1;
  localparam logic [DX_WIDTH-1:0] START_DX_V = DX_WIDTH'(START_DX);
  localparam logic [DY_WIDTH-1:0] START_DY_V = DY_WIDTH'(START_DY);
  localparam logic [CNT_W-1:0]    RELOAD_V   = CNT_W'(RELAUNCH_CYCLES - 1);
  localparam logic signed [X_WIDTH+1:0] X_EDGE = (X_WIDTH+2)'(SCREEN_W - SPRITE_W);
  localparam logic signed [Y_WIDTH+1:0] Y_EDGE = (Y_WIDTH+2)'(SCREEN_H - SPRITE_H);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_XY, S_LOAD_DXY, S_RUN, S_REFLECT, S_LOST, S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [DX_WIDTH-1:0] dx_q, dx_d;
  logic [DY_WIDTH-1:0] dy_q, dy_d;
  logic [7:0]          bounce_q, bounce_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_xy_q, write_xy_d;
  logic                write_dxy_q, write_dxy_d;
  logic                enable_q, enable_d;
  logic                busy_q, busy_d;
  logic                lost_q, lost_d;

  // Signed views widened by two bits so edge limits and |speed| never overflow.
  logic signed [X_WIDTH+1:0] x_s, dx_s;
  logic signed [Y_WIDTH+1:0] y_s, dy_s;
  logic hit_l, hit_r, hit_t, hit_b;

  assign x_s  = $signed({2'b00, sprite_x});
  assign y_s  = $signed({2'b00, sprite_y});
  assign dx_s = (X_WIDTH+2)'($signed(dx_q));
  assign dy_s = (Y_WIDTH+2)'($signed(dy_q));

  assign hit_l = dx_q[DX_WIDTH-1] && (x_s <= -dx_s);
  assign hit_r = !dx_q[DX_WIDTH-1] && (dx_q != '0) && (x_s >= X_EDGE - dx_s);
  assign hit_t = dy_q[DY_WIDTH-1] && (y_s <= -dy_s);
  assign hit_b = !dy_q[DY_WIDTH-1] && (dy_q != '0) && (y_s >= Y_EDGE - dy_s);

  // Most-negative speed has no positive twin; clamp it to +max.
  function automatic logic [DX_WIDTH-1:0] neg_dx(input logic [DX_WIDTH-1:0] v);
    if (v == {1'b1, {(DX_WIDTH-1){1'b0}}}) neg_dx = {1'b0, {(DX_WIDTH-1){1'b1}}};
    else                                   neg_dx = -v;
  endfunction

  function automatic logic [DY_WIDTH-1:0] neg_dy(input logic [DY_WIDTH-1:0] v);
    if (v == {1'b1, {(DY_WIDTH-1){1'b0}}}) neg_dy = {1'b0, {(DY_WIDTH-1){1'b1}}};
    else                                   neg_dy = -v;
  endfunction

  always_comb begin
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    bounce_d = bounce_q;
    cnt_d    = cnt_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d  = S_LOAD_XY;
          bounce_d = 8'd0;
          dx_d     = START_DX_V;
          dy_d     = START_DY_V;
        end
        S_LOAD_XY:  state_d = S_LOAD_DXY;
        S_LOAD_DXY: state_d = S_RUN;
        S_RUN: begin
          if (hit_b && (EXIT_BOTTOM != 0)) begin
            state_d = S_LOST;
          end else if (hit_l || hit_r || hit_t || hit_b) begin
            state_d = S_REFLECT;
            if (hit_l || hit_r) dx_d = neg_dx(dx_q);
            if (hit_t || hit_b) dy_d = neg_dy(dy_q);
            if (bounce_q != 8'hFF) bounce_d = bounce_q + 8'd1;
          end
        end
        S_REFLECT: state_d = S_RUN;
        S_LOST: begin
          state_d = S_WAIT;
          cnt_d   = RELOAD_V;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d = S_LOAD_XY;
            dx_d    = START_DX_V;
            dy_d    = START_DY_V;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs decode the next state so they line up with the state register.
    write_xy_d  = (state_d == S_LOAD_XY);
    write_dxy_d = (state_d == S_LOAD_DXY) || (state_d == S_REFLECT);
    enable_d    = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    lost_d      = (state_d == S_LOST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dx_q        <= START_DX_V;
      dy_q        <= START_DY_V;
      bounce_q    <= 8'd0;
      cnt_q       <= '0;
      write_xy_q  <= 1'b0;
      write_dxy_q <= 1'b0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      bounce_q    <= bounce_d;
      cnt_q       <= cnt_d;
      write_xy_q  <= write_xy_d;
      write_dxy_q <= write_dxy_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      lost_q      <= lost_d;
    end
  end

  assign sprite_write_xy      = write_xy_q;
  assign sprite_write_dxy     = write_dxy_q;
  assign sprite_write_x       = X_WIDTH'(START_X);
  assign sprite_write_y       = Y_WIDTH'(START_Y);
  assign sprite_write_dx      = dx_q;
  assign sprite_write_dy      = dy_q;
  assign sprite_enable_update = enable_q;
  assign busy                 = busy_q;
  assign lost                 = lost_q;
  assign bounce_count         = bounce_q;

endmodule

// File: tb/tb_game_sprite_motion_sequencer.sv
// Directed bench for the sprite motion sequencer; load strobes are checked
// against queued expectations, state-like outputs with immediate checks.
module tb_game_sprite_motion_sequencer;
  localparam int RL = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance: default launch, bottom exit loses the ball
  logic start = 1'b0, stop = 1'b0;
  logic [9:0] sx = 10'd320, sy = 10'd240;
  logic wxy, wdxy, en, bsy, lst;
  logic [9:0] wx, wy;
  logic [1:0] wdx, wdy;
  logic [7:0] bnc;

  // second instance: dx=-2/dy=-1 launch, bottom edge reflects
  logic start2 = 1'b0, stop2 = 1'b0;
  logic [9:0] sx2 = 10'd320, sy2 = 10'd240;
  logic wxy2, wdxy2, en2, bsy2, lst2;
  logic [9:0] wx2, wy2;
  logic [1:0] wdx2, wdy2;
  logic [7:0] bnc2;

  game_sprite_motion_sequencer #(.RELAUNCH_CYCLES(RL)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .sprite_x(sx), .sprite_y(sy),
    .sprite_write_xy(wxy), .sprite_write_dxy(wdxy),
    .sprite_write_x(wx), .sprite_write_y(wy),
    .sprite_write_dx(wdx), .sprite_write_dy(wdy),
    .sprite_enable_update(en), .busy(bsy), .lost(lst), .bounce_count(bnc));

  game_sprite_motion_sequencer #(.RELAUNCH_CYCLES(RL), .START_DX(-2), .START_DY(-1),
                                 .EXIT_BOTTOM(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .stop(stop2),
    .sprite_x(sx2), .sprite_y(sy2),
    .sprite_write_xy(wxy2), .sprite_write_dxy(wdxy2),
    .sprite_write_x(wx2), .sprite_write_y(wy2),
    .sprite_write_dx(wdx2), .sprite_write_dy(wdy2),
    .sprite_enable_update(en2), .busy(bsy2), .lost(lst2), .bounce_count(bnc2));

  int checks = 0;
  int errors = 0;

  logic [19:0] q_xy[$], q2_xy[$];
  logic [3:0]  q_dxy[$], q2_dxy[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every load strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      chk("xy_dxy_exclusive", {31'd0, wxy & wdxy}, 32'd0);
      if (wxy) begin
        chk("xy_expected", {31'd0, q_xy.size() > 0}, 32'd1);
        if (q_xy.size() > 0) chk("xy_value", {12'd0, wx, wy}, {12'd0, q_xy.pop_front()});
      end
      if (wdxy) begin
        chk("dxy_expected", {31'd0, q_dxy.size() > 0}, 32'd1);
        if (q_dxy.size() > 0) chk("dxy_value", {28'd0, wdx, wdy}, {28'd0, q_dxy.pop_front()});
      end
      if (wxy2) begin
        chk("xy2_expected", {31'd0, q2_xy.size() > 0}, 32'd1);
        if (q2_xy.size() > 0) chk("xy2_value", {12'd0, wx2, wy2}, {12'd0, q2_xy.pop_front()});
      end
      if (wdxy2) begin
        chk("dxy2_expected", {31'd0, q2_dxy.size() > 0}, 32'd1);
        if (q2_dxy.size() > 0) chk("dxy2_value", {28'd0, wdx2, wdy2}, {28'd0, q2_dxy.pop_front()});
      end
    end
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", bsy, 0);
    chk("rst_en", en, 0);
    chk("rst_lost", lst, 0);
    chk("rst_dx", wdx, 1);
    chk("rst_dy", wdy, 1);
    chk("rst_bounce", bnc, 0);

    // launch
    q_xy.push_back({10'd320, 10'd240});
    q_dxy.push_back({2'b01, 2'b01});
    start = 1'b1; tick(); start = 1'b0;
    chk("launch_wxy", wxy, 1);
    chk("launch_busy", bsy, 1);
    chk("launch_en0", en, 0);
    tick();
    chk("launch_wdxy", wdxy, 1);
    chk("launch_wxy_off", wxy, 0);
    tick();
    chk("run_en", en, 1);
    tick();
    chk("run_en_steady", en, 1);

    // right edge boundary
    sx = 10'd630; tick();
    chk("x630_no_hit", en, 1);
    chk("x630_bounce", bnc, 0);
    sx = 10'd631;
    q_dxy.push_back({2'b11, 2'b01});
    tick();
    chk("right_en0", en, 0);
    chk("right_bounce", bnc, 1);
    sx = 10'd320; tick();
    chk("right_back_run", en, 1);

    // bottom exit boundary, lost and relaunch
    sy = 10'd470; tick();
    chk("y470_no_hit", en, 1);
    sy = 10'd471; tick();
    chk("lost_pulse", lst, 1);
    chk("lost_en0", en, 0);
    chk("lost_busy", bsy, 1);
    sy = 10'd240;
    q_xy.push_back({10'd320, 10'd240});
    q_dxy.push_back({2'b01, 2'b01});
    for (int i = 0; i < RL; i++) begin
      tick();
      chk("wait_quiet", {29'd0, lst, en, wxy}, 32'd0);
    end
    tick();
    chk("relaunch_wxy", wxy, 1);
    chk("relaunch_bounce_kept", bnc, 1);
    tick();
    tick();
    chk("relaunch_run", en, 1);

    // stop in RUN, start+stop in IDLE
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_run_busy", bsy, 0);
    chk("stop_run_en", en, 0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("startstop_busy", bsy, 0);
    chk("startstop_wxy", wxy, 0);
    q_xy.push_back({10'd320, 10'd240});
    q_dxy.push_back({2'b01, 2'b01});
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_wxy", wxy, 1);
    chk("restart_bounce0", bnc, 0);
    tick(); tick();
    sy = 10'd471; tick(); sy = 10'd240;
    chk("lost2_pulse", lst, 1);
    tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_wait_busy", bsy, 0);
    chk("stop_wait_lost", lst, 0);
    tick();
    chk("idle_stays", bsy, 0);

    // reset mid-RUN
    q_xy.push_back({10'd320, 10'd240});
    q_dxy.push_back({2'b01, 2'b01});
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    sx = 10'd631;
    q_dxy.push_back({2'b11, 2'b01});
    tick(); sx = 10'd320;
    chk("pre_reset_bounce", bnc, 1);
    tick();
    chk("pre_reset_dx", wdx, 2'b11);
    reset = 1'b1; #1;
    chk("async_rst_busy", bsy, 0);
    chk("async_rst_en", en, 0);
    chk("async_rst_dx", wdx, 1);
    chk("async_rst_bounce", bnc, 0);
    tick(); reset = 1'b0; tick();

    // second instance: saturated negation, corner, reflecting bottom
    q2_xy.push_back({10'd320, 10'd240});
    q2_dxy.push_back({2'b10, 2'b11});
    start2 = 1'b1; tick(); start2 = 1'b0;
    tick(); tick();
    chk("d2_run", en2, 1);
    sx2 = 10'd3; tick();
    chk("d2_x3_no_hit", en2, 1);
    sx2 = 10'd2;
    q2_dxy.push_back({2'b01, 2'b11});
    tick(); sx2 = 10'd320;
    chk("d2_sat_en0", en2, 0);
    chk("d2_sat_bounce", bnc2, 1);
    tick();
    sx2 = 10'd631;
    q2_dxy.push_back({2'b11, 2'b11});
    tick(); sx2 = 10'd320;
    chk("d2_right_bounce", bnc2, 2);
    tick();
    sx2 = 10'd1; sy2 = 10'd1;
    q2_dxy.push_back({2'b01, 2'b01});
    tick(); sx2 = 10'd320; sy2 = 10'd240;
    chk("d2_corner_bounce", bnc2, 3);
    chk("d2_corner_en0", en2, 0);
    tick();
    chk("d2_corner_run", en2, 1);
    sy2 = 10'd471;
    q2_dxy.push_back({2'b01, 2'b11});
    tick(); sy2 = 10'd240;
    chk("d2_bottom_not_lost", lst2, 0);
    chk("d2_bottom_bounce", bnc2, 4);
    tick();
    chk("d2_bottom_run", en2, 1);
    tick();

    chk("q_xy_drained", q_xy.size(), 0);
    chk("q_dxy_drained", q_dxy.size(), 0);
    chk("q2_xy_drained", q2_xy.size(), 0);
    chk("q2_dxy_drained", q2_dxy.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
